decoder_onehot_seq: RTL and testbench
=====================================

// Module: decoder_onehot_seq
// PURPOSE
//  Parametrised registered binary-to-one-hot decoder: SEL_W-bit select to OUT_W=2**SEL_W lines.
//  Two modes:
//  - DIRECT: decodes an accepted select value.
//  - SCAN: sweeps the lines in order, dwelling on each line for a programmable time.
//  Drives row/digit strobes for keypad and display scanning and chip-select fan-out.
// PARAMETERS
//  SEL_W      4  select width; OUT_W=2**SEL_W is a derived localparam, not overridable
//  DWELL_W    8  width of dwell count; each scanned line is held dwell+1 cycles
//  ACTIVE_LOW 0  1 = y inverted at output (idle all-ones, selected line 0)
// PORTS
//  clk        in   1        clock; all state changes on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  en         in   1        block enable; 0 forces outputs inactive
//  mode       in   1        0 = DIRECT, 1 = SCAN
//  sel        in   SEL_W    select value (DIRECT)
//  sel_valid  in   1        sel is valid
//  sel_ready  out  1        block accepts sel this cycle
//  dwell      in   DWELL_W  per-line hold count (SCAN), sampled at start of each slot
//  y          out  OUT_W    one-hot (or one-cold) decoded lines, registered
//  y_idx      out  SEL_W    index of currently active line, registered
//  wrap       out  1        one-cycle pulse when scan returns from OUT_W-1 to 0
//  busy       out  1        1 while in SCAN state
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - state=IDLE, y=inactive (all 0, or all 1 if ACTIVE_LOW), y_idx=0, wrap=0, busy=0, dwell counter=0.
//  States IDLE, DIRECT, SCAN; next state is evaluated every cycle.
//   - en=0: ->IDLE.
//   - en=1, mode=0: ->DIRECT.
//   - en=1, mode=1: ->SCAN.
//  Priority: rst_n > en=0 > mode > sel_valid.
//  IDLE
//   - y inactive, sel_ready=0, y_idx holds 0.
//  DIRECT
//   - sel_ready=1 combinationally whenever en=1 && mode=0.
//   - Accept on sel_valid && sel_ready.
//   - Latency 1: cycle after accept, y=1<<sel and y_idx=sel.
//   - y holds until the next accept; back-to-back accepts update every cycle.
//   - Entering DIRECT from IDLE or SCAN: y inactive until the first accept.
//  SCAN
//   - sel_ready=0; sel and sel_valid are ignored.
//   - Cycle after entry: y_idx=0, y=1<<0, dwell counter loaded with dwell.
//   - Counter decrements each cycle. At 0, the next edge advances y_idx by 1 and reloads dwell.
//   - dwell=0: advances every cycle.
//   - Wrap: y_idx=OUT_W-1 advances to 0. wrap=1 in the same cycle y_idx shows 0, otherwise wrap=0.
//   - No wrap pulse on initial entry.
//   - A dwell change mid-slot takes effect at the next slot.
//  Mode changes
//   - SCAN->DIRECT: y inactive next cycle; counter cleared.
//   - DIRECT->SCAN: restarts at index 0.
//   - en falling mid-slot: y inactive next cycle; re-enable in SCAN restarts at index 0.
//  Outputs
//   - Exactly one line active whenever state != IDLE and a line has been selected; never more than one.
//   - ACTIVE_LOW inverts y only; y_idx, wrap and busy are unaffected.
//   - busy = (state==SCAN), registered.
// STRUCTURE
//  Shared package decoder_pkg:
//   - state encoding constants ST_IDLE/ST_DIRECT/ST_SCAN (2 bits).
//   - MODE_DIRECT/MODE_SCAN constants.
//   - function onehot(idx) returning 1<<idx at OUT_W width.
//  One sub-module, dwell_counter: load, decrement, zero flag; DWELL_W-parametrised.
//  Decode and FSM stay in this module.
// TESTING (SEL_W=4, DWELL_W=8 unless noted)
//  1. Reset with en=1, mode=0 -> y=16'h0000, y_idx=0, wrap=0, busy=0, sel_ready=1 after release.
//  2. DIRECT: sel=0..15 back-to-back with sel_valid=1 -> y=16'h0001..16'h8000, one cycle after each accept.
//  3. SCAN, dwell=2 -> each line held 3 cycles; y_idx 0..15 then 0; wrap high exactly one cycle at the return to 0 (cycle 49 after entry).
//  4. SCAN, dwell=0 -> advance every cycle. Change dwell to 5 mid-slot -> new hold takes effect from the next line.
//  5. SCAN at y_idx=7: switch mode=0 -> y=0 next cycle; sel=3 accepted -> y=16'h0008.
//     Then en=0 -> y=0, busy=0.
//  6. ACTIVE_LOW=1, SEL_W=3: reset -> y=8'hFF; DIRECT sel=5 -> y=8'hDF.
//     rst_n asserted mid-scan -> outputs inactive immediately, without waiting for clk.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// onehot() works at a fixed maximum width; callers truncate to their own OUT_W.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Per-line hold counter for scan mode: loadable down-counter with a zero flag.
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - DWELL_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with a direct-select mode and a timed scan mode.
// All outputs come from registers; ACTIVE_LOW only inverts the final y lines.
module decoder_onehot_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      y_idx,
  output logic                  wrap,
  output logic                  busy
);

  localparam int OUT_W = 2 ** SEL_W;

  state_t             state;
  logic [OUT_W-1:0]   y_q;
  logic [SEL_W-1:0]   idx_next;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [DWELL_W-1:0] cnt_val;

  assign sel_ready = en && (mode == MODE_DIRECT);
  assign idx_next  = y_idx + SEL_W'(1);

  // The counter is cleared whenever scan is not running, and reloaded at each slot start.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = dwell;
    if (!en || mode == MODE_DIRECT) begin
      cnt_load = 1'b1;
      cnt_val  = '0;
    end else if (state != ST_SCAN || cnt_zero) begin
      cnt_load = 1'b1;
    end else begin
      cnt_dec = 1'b1;
    end
  end

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      y_q   <= '0;
      y_idx <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else if (!en) begin
      state <= ST_IDLE;
      y_q   <= '0;
      y_idx <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else if (mode == MODE_DIRECT) begin
      state <= ST_DIRECT;
      wrap  <= 1'b0;
      busy  <= 1'b0;
      // An accept on the entry cycle is honoured; otherwise entry blanks y until one arrives.
      if (sel_valid) begin
        y_q   <= OUT_W'(onehot(MAX_SEL_W'(sel)));
        y_idx <= sel;
      end else if (state != ST_DIRECT) begin
        y_q   <= '0;
        y_idx <= '0;
      end
    end else begin
      state <= ST_SCAN;
      busy  <= 1'b1;
      if (state != ST_SCAN) begin
        y_q   <= OUT_W'(onehot(MAX_SEL_W'(0)));
        y_idx <= '0;
        wrap  <= 1'b0;
      end else if (cnt_zero) begin
        y_q   <= OUT_W'(onehot(MAX_SEL_W'(idx_next)));
        y_idx <= idx_next;
        wrap  <= (idx_next == '0);
      end else begin
        wrap  <= 1'b0;
      end
    end
  end

  assign y = ACTIVE_LOW ? ~y_q : y_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Randomised self-checking bench for decoder_onehot_seq against a slot-based reference model.
// A second instance (SEL_W=3, ACTIVE_LOW=1) covers inverted outputs and asynchronous reset.
module tb_decoder_onehot_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, sel_valid;
  logic [3:0]  sel;
  logic [7:0]  dwell;
  logic        sel_ready, wrap, busy;
  logic [15:0] y;
  logic [3:0]  y_idx;

  logic        rst2_n, en2, mode2, sel_valid2;
  logic [2:0]  sel2;
  logic [7:0]  dwell2;
  logic        sel_ready2, wrap2, busy2;
  logic [7:0]  y2;
  logic [2:0]  y_idx2;

  int errors = 0;
  int checks = 0;

  // Reference model: which line is shown, how long it has been shown, and its slot length.
  int m_state;
  bit m_active;
  int m_idx;
  bit m_wrap;
  int m_age;
  int m_len;

  always #5 clk = ~clk;

  decoder_onehot_seq #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .dwell(dwell), .y(y), .y_idx(y_idx), .wrap(wrap), .busy(busy)
  );

  decoder_onehot_seq #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_low (
    .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2), .sel(sel2), .sel_valid(sel_valid2),
    .sel_ready(sel_ready2), .dwell(dwell2), .y(y2), .y_idx(y_idx2), .wrap(wrap2), .busy(busy2)
  );

  function automatic logic [15:0] exp_y();
    return m_active ? (16'h0001 << m_idx) : 16'h0000;
  endfunction

  task automatic model_reset();
    m_state = 0; m_active = 0; m_idx = 0; m_wrap = 0; m_age = 0; m_len = 1;
  endtask

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (!en) begin
      m_state = 0; m_active = 0; m_idx = 0; m_wrap = 0;
    end else if (mode == 1'b0) begin
      if (sel_valid) begin
        m_active = 1; m_idx = int'(sel);
      end else if (m_state != 1) begin
        m_active = 0; m_idx = 0;
      end
      m_state = 1; m_wrap = 0;
    end else begin
      if (m_state != 2) begin
        m_idx = 0; m_age = 0; m_len = int'(dwell) + 1; m_wrap = 0;
      end else begin
        m_age++;
        m_wrap = 0;
        if (m_age == m_len) begin
          m_idx  = (m_idx + 1) % 16;
          m_wrap = (m_idx == 0);
          m_age  = 0;
          m_len  = int'(dwell) + 1;
        end
      end
      m_active = 1; m_state = 2;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 4'd0; sel_valid = 1'b0; dwell = 8'd0;
    rst2_n = 1'b0; en2 = 1'b0; mode2 = 1'b0; sel2 = 3'd0; sel_valid2 = 1'b0; dwell2 = 8'd0;
    model_reset();
    #12;
    checks++;
    if (y !== 16'h0000) begin errors++; $display("[TB] FAIL reset_y: got %h expected %h", y, 16'h0000); end
    checks++;
    if (y_idx !== 4'd0 || wrap !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got idx=%0d wrap=%b busy=%b expected 0 0 0", y_idx, wrap, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (sel_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_sel_ready: got %b expected 1", sel_ready); end
  endtask

  task automatic test_direct();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      sel = 4'(i); sel_valid = 1'b1;
      tick();
      checks++;
      if (y !== (16'h0001 << i) || y_idx !== 4'(i)) begin
        errors++; $display("[TB] FAIL direct_sweep_%0d: got y=%h idx=%0d expected y=%h idx=%0d", i, y, y_idx, 16'h0001 << i, i);
      end
    end
    for (int i = 0; i < 24; i++) begin
      sel = 4'($urandom_range(0, 15)); sel_valid = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (y !== exp_y() || y_idx !== 4'(m_idx) || busy !== 1'b0 || sel_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL direct_random_%0d: got y=%h idx=%0d busy=%b expected y=%h idx=%0d busy=0", i, y, y_idx, busy, exp_y(), m_idx);
      end
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_scan_dwell2();
    int wraps;
    wraps = 0;
    mode = 1'b1; dwell = 8'd2;
    for (int t = 1; t <= 52; t++) begin
      sel = 4'($urandom_range(0, 15)); sel_valid = 1'($urandom_range(0, 1));
      tick();
      if (wrap === 1'b1) wraps++;
      checks++;
      if (y_idx !== 4'(((t - 1) / 3) % 16) || wrap !== (t == 49) || busy !== 1'b1 ||
          y !== (16'h0001 << (((t - 1) / 3) % 16)) || sel_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL scan_dwell2_t%0d: got idx=%0d wrap=%b busy=%b y=%h expected idx=%0d wrap=%b busy=1",
                           t, y_idx, wrap, busy, y, ((t - 1) / 3) % 16, (t == 49));
      end
    end
    checks++;
    if (wraps != 1) begin errors++; $display("[TB] FAIL scan_wrap_count: got %0d expected 1", wraps); end
  endtask

  task automatic test_scan_dwell_change();
    mode = 1'b0; sel_valid = 1'b0;
    tick();
    mode = 1'b1; dwell = 8'd0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (y_idx !== 4'(t - 1)) begin errors++; $display("[TB] FAIL scan_dwell0_t%0d: got idx=%0d expected %0d", t, y_idx, t - 1); end
    end
    dwell = 8'd5;
    for (int t = 6; t <= 17; t++) begin
      tick();
      checks++;
      if (y_idx !== 4'(t < 12 ? 5 : 6)) begin
        errors++; $display("[TB] FAIL scan_dwell5_t%0d: got idx=%0d expected %0d", t, y_idx, t < 12 ? 5 : 6);
      end
    end
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 3) == 0) dwell = 8'($urandom_range(0, 3));
      sel = 4'($urandom_range(0, 15)); sel_valid = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (y !== exp_y() || y_idx !== 4'(m_idx) || wrap !== m_wrap || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL scan_random_%0d: got y=%h idx=%0d wrap=%b expected y=%h idx=%0d wrap=%b",
                           i, y, y_idx, wrap, exp_y(), m_idx, m_wrap);
      end
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_mode_switch();
    mode = 1'b0;
    tick();
    mode = 1'b1; dwell = 8'd0;
    for (int t = 0; t < 8; t++) tick();
    checks++;
    if (y_idx !== 4'd7) begin errors++; $display("[TB] FAIL switch_at7: got idx=%0d expected 7", y_idx); end
    mode = 1'b0; sel_valid = 1'b0;
    tick();
    checks++;
    if (y !== 16'h0000 || busy !== 1'b0 || sel_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL switch_to_direct: got y=%h busy=%b ready=%b expected 0000 0 1", y, busy, sel_ready);
    end
    sel = 4'd3; sel_valid = 1'b1;
    tick();
    checks++;
    if (y !== 16'h0008 || y_idx !== 4'd3) begin
      errors++; $display("[TB] FAIL switch_accept3: got y=%h idx=%0d expected 0008 3", y, y_idx);
    end
    en = 1'b0; sel_valid = 1'b0;
    tick();
    checks++;
    if (y !== 16'h0000 || busy !== 1'b0 || y_idx !== 4'd0 || sel_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL disable: got y=%h busy=%b idx=%0d ready=%b expected 0000 0 0 0", y, busy, y_idx, sel_ready);
    end
    en = 1'b1; mode = 1'b1; dwell = 8'd1;
    tick();
    checks++;
    if (y !== 16'h0001 || y_idx !== 4'd0 || busy !== 1'b1 || wrap !== 1'b0) begin
      errors++; $display("[TB] FAIL reenable_scan: got y=%h idx=%0d busy=%b wrap=%b expected 0001 0 1 0", y, y_idx, busy, wrap);
    end
    checks++;
    if (y !== exp_y() || y_idx !== 4'(m_idx)) begin
      errors++; $display("[TB] FAIL reenable_model: got y=%h idx=%0d expected y=%h idx=%0d", y, y_idx, exp_y(), m_idx);
    end
  endtask

  task automatic test_active_low();
    #1;
    checks++;
    if (y2 !== 8'hFF) begin errors++; $display("[TB] FAIL al_reset_y: got %h expected FF", y2); end
    @(negedge clk);
    rst2_n = 1'b1; en2 = 1'b1; mode2 = 1'b0; sel2 = 3'd5; sel_valid2 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (y2 !== 8'hDF || y_idx2 !== 3'd5) begin
      errors++; $display("[TB] FAIL al_direct5: got y=%h idx=%0d expected DF 5", y2, y_idx2);
    end
    sel_valid2 = 1'b0; mode2 = 1'b1; dwell2 = 8'd1;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    checks++;
    if (busy2 !== 1'b1 || y2 !== ~(8'h01 << 2) || y_idx2 !== 3'd2) begin
      errors++; $display("[TB] FAIL al_scan: got y=%h idx=%0d busy=%b expected %h 2 1", y2, y_idx2, busy2, ~(8'h01 << 2));
    end
    #2;
    rst2_n = 1'b0;
    #1;
    checks++;
    if (y2 !== 8'hFF || busy2 !== 1'b0 || y_idx2 !== 3'd0 || wrap2 !== 1'b0) begin
      errors++; $display("[TB] FAIL al_async_reset: got y=%h busy=%b idx=%0d wrap=%b expected FF 0 0 0", y2, busy2, y_idx2, wrap2);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_dwell2();
    test_scan_dwell_change();
    test_mode_switch();
    test_active_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
